decode_control: RTL and testbench
=================================

Name: decode_control

Overview:
- Stage-2 (decode/issue) controller of the 5-stage 8-bit pipeline; sits directly downstream of the fetch controller.
- Consumes IR1 and the fetch IR1Load strobe, and decides each cycle whether IR1 advances into IR2 or a bubble is inserted.
- Detects register and flag RAW hazards against IR2/IR3/IR4, back-pressures fetch, flushes on taken branch, and sequences STOP into a drained halt.

Parameters:
- STALL_CNT_W, 8, width of the saturating stall-cycle counter (only present under the optional feature).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- IR1wire_out  in  8  IR1 contents; opcode [3:0], R1 field [7:6], R2 field [5:4].
- IR1Load  in  1  fetch loaded IR1 this edge.
- IR3wire_out  in  8  IR3 contents.
- IR3Valid  in  1  IR3 holds a real instruction.
- IR4wire_out  in  8  IR4 contents.
- IR4Valid  in  1  IR4 holds a real instruction.
- BranchTaken  in  1  taken branch resolved downstream; flush stages 1-2.
- IR2Load  out  1  load IR1 into IR2 this edge.
- IR2Valid  out  1  IR2 holds a real instruction (registered).
- FetchStall  out  1  fetch must hold PC and IR1.
- RegA  out  2  register-file read address A.
- RegB  out  2  register-file read address B.
- Halted  out  1  pipeline drained after STOP.
- StallCount  out  STALL_CNT_W  stall cycles; present only with DECODE_PERF_CNT_EN.

Behaviour:
- Opcode classes:
  - load 0000: reads R2, writes R1.
  - store 0010: reads R1 and R2.
  - add 0100, sub 0110, nand 1000: read R1 and R2, write R1, set flags.
  - ori [2:0]=111: reads and writes register 1, sets flags.
  - shift [2:0]=011: reads and writes R1, sets flags.
  - bz 0101, bnz 1001, bpz 1101: read flags only.
  - stop 0001: no operands.
  - nop 1010: no operands.
- RegA = R1 field (forced to 01 for ori); RegB = R2 field. Combinational from IR1wire_out.
- Internal registered state:
  - ir1_valid: set on an edge where IR1Load=1; cleared when consumed without reload or on flush.
  - ir2 destination and flag-writer bits, captured on IR2Load.
  - 2-bit FSM: RUN, DRAIN, HALT.
- Hazard (combinational) = ir1_valid and any of:
  - a source register of IR1 equals the destination of a valid IR2, IR3 or IR4 writer;
  - IR1 is a branch and any valid IR2/IR3/IR4 is a flag writer.
- IR2Load = state==RUN & ir1_valid & !hazard & !BranchTaken & IR1 not stop.
- FetchStall = ir1_valid & (hazard | state!=RUN) & !BranchTaken.
- IR2Valid next = IR2Load; otherwise a bubble (0) is inserted.
- BranchTaken has highest priority:
  - ir1_valid<=0 and IR2Valid<=0 next edge;
  - a STOP in DRAIN is wrong-path, so state returns to RUN.
- STOP handling:
  - In RUN, a valid STOP in IR1 with no hazard and no BranchTaken goes to DRAIN; ir1_valid is cleared and STOP is not issued.
  - DRAIN goes to HALT on the first edge with IR2Valid, IR3Valid and IR4Valid all 0.
  - HALT: Halted=1, IR2Load=0, FetchStall=1; exited only by reset.
- Latency: a hazard-free instruction loaded into IR1 at edge N is in IR2 at edge N+1.
- Simultaneous IR1Load and consume on the same edge: ir1_valid stays 1.
- Reset (any time, mid-stall or mid-drain):
  - IR2Load=0, IR2Valid=0, FetchStall=0, Halted=0;
  - ir1_valid=0, state=RUN, StallCount=0.

Optional Feature:
- DECODE_PERF_CNT_EN defined: StallCount port exists.
  - Increments on each edge where FetchStall=1 and state==RUN.
  - Saturates at all-ones; cleared only by reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset mid-DRAIN -> next cycle: IR2Valid=0, Halted=0, FetchStall=0, state RUN.
- IR1=8'b01_00_0100 (add r1,r0), IR2/3/4 empty, IR1Load pulse -> IR2Load=1 that cycle, IR2Valid=1 next edge; RegA=01, RegB=00.
- IR3 = load writing r2 (IR3Valid=1); IR1 = add r2,r3 -> FetchStall=1, IR2Load=0, IR2Valid=0.
  - IR3Valid drops and IR4 holds the same load -> stall continues.
  - IR4Valid=0 -> IR2Load=1 the same cycle.
- IR1 = bz, valid add in IR3 -> stall.
  - Assert BranchTaken while stalled -> next edge: ir1_valid=0, IR2Valid=0, FetchStall=0.
- IR1 = 0001 (stop), valid ops in IR2 and IR3 -> DRAIN, IR2Load=0.
  - Halted=1 two edges after IR3Valid and IR4Valid go low; stays 1 for 20 cycles of IR1Load pulses.
- With DECODE_PERF_CNT_EN, STALL_CNT_W=2: 5 consecutive hazard stall cycles -> StallCount=3 (saturated).

Source files
------------

// File: rtl/decode_control.sv
`default_nettype none
// ============================================================================
// Module   : decode_control
// Purpose  : Stage-2 (decode/issue) controller of the 5-stage 8-bit pipeline.
//            Each cycle it decides whether IR1 advances into IR2 or a bubble
//            is inserted. It detects register and flag RAW hazards against
//            IR2/IR3/IR4, back-pressures fetch, flushes on a taken branch and
//            sequences STOP into a drained halt.
// Option   : DECODE_PERF_CNT_EN -- when defined, adds the STALL_CNT_W
//            parameter and a saturating StallCount output.
// Ports    :
//   clock        in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   IR1wire_out  in   IR1 contents: opcode [3:0], R1 [7:6], R2 [5:4]
//   IR1Load      in   fetch loads IR1 on this edge
//   IR3wire_out  in   IR3 contents
//   IR3Valid     in   IR3 holds a real instruction
//   IR4wire_out  in   IR4 contents
//   IR4Valid     in   IR4 holds a real instruction
//   BranchTaken  in   taken branch resolved downstream; flush stages 1-2
//   IR2Load      out  load IR1 into IR2 on this edge
//   IR2Valid     out  IR2 holds a real instruction
//   FetchStall   out  fetch must hold PC and IR1
//   RegA         out  register-file read address A
//   RegB         out  register-file read address B
//   Halted       out  pipeline drained after STOP
//   StallCount   out  saturating stall-cycle count (option only)
// Revision : 1.0 - initial release
// ============================================================================
module decode_control
`ifdef DECODE_PERF_CNT_EN
#(
  parameter int STALL_CNT_W = 8
)
`endif
(
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] IR1wire_out,
  input  logic       IR1Load,
  input  logic [7:0] IR3wire_out,
  input  logic       IR3Valid,
  input  logic [7:0] IR4wire_out,
  input  logic       IR4Valid,
  input  logic       BranchTaken,
  output logic       IR2Load,
  output logic       IR2Valid,
  output logic       FetchStall,
  output logic [1:0] RegA,
  output logic [1:0] RegB,
  output logic       Halted
`ifdef DECODE_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] StallCount
`endif
);

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STOP  = 4'b0001;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_BPZ   = 4'b1101;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  // What an instruction writes: a register (and which) and/or the flags.
  typedef struct packed {
    logic       wr;
    logic [1:0] dst;
    logic       flags;
  } wr_t;

  // What an instruction in IR1 reads.
  typedef struct packed {
    logic rd_a;      // reads the register addressed by RegA
    logic rd_b;      // reads the register addressed by RegB
    logic rd_flags;  // conditional branch
    logic is_stop;
  } rd_t;

  function automatic wr_t writes(input logic [7:0] ir);
    wr_t w;
    w     = '0;
    w.dst = ir[7:6];
    if (ir[2:0] == 3'b111) begin          // ori: implicit register 1
      w.wr    = 1'b1;
      w.dst   = 2'b01;
      w.flags = 1'b1;
    end else if (ir[2:0] == 3'b011) begin // shift
      w.wr    = 1'b1;
      w.flags = 1'b1;
    end else begin
      case (ir[3:0])
        OP_LOAD:                 w.wr = 1'b1;
        OP_ADD, OP_SUB, OP_NAND: begin
          w.wr    = 1'b1;
          w.flags = 1'b1;
        end
        default: ;
      endcase
    end
    return w;
  endfunction

  function automatic rd_t reads(input logic [7:0] ir);
    rd_t r;
    r = '0;
    if (ir[2:0] == 3'b111 || ir[2:0] == 3'b011) begin
      r.rd_a = 1'b1;                      // ori / shift: one register operand
    end else begin
      case (ir[3:0])
        OP_LOAD:                           r.rd_b = 1'b1;
        OP_STORE, OP_ADD, OP_SUB, OP_NAND: begin
          r.rd_a = 1'b1;
          r.rd_b = 1'b1;
        end
        OP_BZ, OP_BNZ, OP_BPZ:             r.rd_flags = 1'b1;
        OP_STOP:                           r.is_stop  = 1'b1;
        default: ;
      endcase
    end
    return r;
  endfunction

  function automatic logic conflicts(input rd_t r, input logic [1:0] ra,
                                     input logic [1:0] rb, input logic v,
                                     input wr_t w);
    return v & ((w.wr & ((r.rd_a & (ra == w.dst)) | (r.rd_b & (rb == w.dst))))
                | (r.rd_flags & w.flags));
  endfunction

  state_t     state_q, state_d;
  logic       ir1_valid_q, ir1_valid_d;
  logic       ir2_valid_q, ir2_valid_d;
  wr_t        ir2_wr_q, ir2_wr_d;
  logic       halted_q;

  rd_t        ir1_rd;
  wr_t        ir1_wr, ir3_wr, ir4_wr;
  logic       hazard;
  logic       stop_accept;
  logic       run;
  logic [3:0] unused_bits;

  // Only opcode and destination fields of IR3/IR4 matter for hazards.
  assign unused_bits = {IR3wire_out[5:4], IR4wire_out[5:4]};

  assign ir1_rd = reads(IR1wire_out);
  assign ir1_wr = writes(IR1wire_out);
  assign ir3_wr = writes(IR3wire_out);
  assign ir4_wr = writes(IR4wire_out);

  assign RegA = (IR1wire_out[2:0] == 3'b111) ? 2'b01 : IR1wire_out[7:6];
  assign RegB = IR1wire_out[5:4];

  assign run    = (state_q == S_RUN);
  assign hazard = ir1_valid_q &
                  (conflicts(ir1_rd, RegA, RegB, ir2_valid_q, ir2_wr_q) |
                   conflicts(ir1_rd, RegA, RegB, IR3Valid,    ir3_wr)   |
                   conflicts(ir1_rd, RegA, RegB, IR4Valid,    ir4_wr));

  // STOP is consumed without being issued; it only starts the drain.
  assign stop_accept = run & ir1_valid_q & ~hazard & ~BranchTaken & ir1_rd.is_stop;
  assign IR2Load     = run & ir1_valid_q & ~hazard & ~BranchTaken & ~ir1_rd.is_stop;

  // Once halted, fetch is frozen regardless of IR1 occupancy.
  assign FetchStall = (state_q == S_HALT) |
                      (ir1_valid_q & (hazard | ~run) & ~BranchTaken);

  assign IR2Valid = ir2_valid_q;
  assign Halted   = halted_q;

  always_comb begin
    state_d     = state_q;
    ir1_valid_d = ir1_valid_q;
    ir2_valid_d = IR2Load;
    ir2_wr_d    = IR2Load ? ir1_wr : ir2_wr_q;

    // A reload on the same edge as a consume keeps IR1 occupied.
    if (BranchTaken)                  ir1_valid_d = 1'b0;
    else if (IR1Load)                 ir1_valid_d = 1'b1;
    else if (IR2Load || stop_accept)  ir1_valid_d = 1'b0;

    case (state_q)
      S_RUN: begin
        if (stop_accept) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // A taken branch means the STOP was on the wrong path.
        if (BranchTaken)                                 state_d = S_RUN;
        else if (!ir2_valid_q && !IR3Valid && !IR4Valid) state_d = S_HALT;
      end
      S_HALT: ;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_RUN;
      ir1_valid_q <= 1'b0;
      ir2_valid_q <= 1'b0;
      ir2_wr_q    <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir1_valid_q <= ir1_valid_d;
      ir2_valid_q <= ir2_valid_d;
      ir2_wr_q    <= ir2_wr_d;
      halted_q    <= (state_d == S_HALT);
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (FetchStall && run && (stall_cnt_q != {STALL_CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign StallCount = stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_control
// Purpose  : Self-checking bench for decode_control: directed scenarios plus
//            randomized traffic compared against a behavioural model built
//            from register/flag read-write sets per opcode.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_control;

  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [7:0] ADD_R1_R0 = 8'b01_00_0100;
  localparam logic [7:0] LD_R2     = 8'b10_00_0000;
  localparam logic [7:0] ADD_R2_R3 = 8'b10_11_0100;
  localparam logic [7:0] BZ        = 8'b00_00_0101;
  localparam logic [7:0] STOP      = 8'b00_00_0001;
  localparam logic [7:0] NOP       = 8'b00_00_1010;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] IR1wire_out = '0;
  logic       IR1Load = 1'b0;
  logic [7:0] IR3wire_out = '0;
  logic       IR3Valid = 1'b0;
  logic [7:0] IR4wire_out = '0;
  logic       IR4Valid = 1'b0;
  logic       BranchTaken = 1'b0;
  logic       IR2Load, IR2Valid, FetchStall, Halted;
  logic [1:0] RegA, RegB;
`ifdef DECODE_PERF_CNT_EN
  logic [CW-1:0] StallCount;
`endif

  always #5 clock = ~clock;

`ifdef DECODE_PERF_CNT_EN
  decode_control #(.STALL_CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .IR1wire_out (IR1wire_out),
    .IR1Load     (IR1Load),
    .IR3wire_out (IR3wire_out),
    .IR3Valid    (IR3Valid),
    .IR4wire_out (IR4wire_out),
    .IR4Valid    (IR4Valid),
    .BranchTaken (BranchTaken),
    .IR2Load     (IR2Load),
    .IR2Valid    (IR2Valid),
    .FetchStall  (FetchStall),
    .RegA        (RegA),
    .RegB        (RegB),
    .Halted      (Halted),
    .StallCount  (StallCount)
  );
`else
  decode_control dut (
    .clock       (clock),
    .reset       (reset),
    .IR1wire_out (IR1wire_out),
    .IR1Load     (IR1Load),
    .IR3wire_out (IR3wire_out),
    .IR3Valid    (IR3Valid),
    .IR4wire_out (IR4wire_out),
    .IR4Valid    (IR4Valid),
    .BranchTaken (BranchTaken),
    .IR2Load     (IR2Load),
    .IR2Valid    (IR2Valid),
    .FetchStall  (FetchStall),
    .RegA        (RegA),
    .RegB        (RegB),
    .Halted      (Halted)
  );
`endif

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_value(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Set of registers an instruction reads (bit i = register i).
  function automatic logic [3:0] rmask(input logic [7:0] ir);
    logic [3:0] m;
    m = '0;
    case (ir[3:0])
      4'b0000:                            m[ir[5:4]] = 1'b1;
      4'b0010, 4'b0100, 4'b0110, 4'b1000: begin
        m[ir[7:6]] = 1'b1;
        m[ir[5:4]] = 1'b1;
      end
      4'b0111, 4'b1111:                   m[1] = 1'b1;
      4'b0011, 4'b1011:                   m[ir[7:6]] = 1'b1;
      default: ;
    endcase
    return m;
  endfunction

  // Set of registers an instruction writes.
  function automatic logic [3:0] wmask(input logic [7:0] ir);
    logic [3:0] m;
    m = '0;
    case (ir[3:0])
      4'b0000, 4'b0100, 4'b0110, 4'b1000, 4'b0011, 4'b1011: m[ir[7:6]] = 1'b1;
      4'b0111, 4'b1111:                                     m[1] = 1'b1;
      default: ;
    endcase
    return m;
  endfunction

  function automatic logic sets_flags(input logic [7:0] ir);
    case (ir[3:0])
      4'b0100, 4'b0110, 4'b1000, 4'b0111, 4'b1111, 4'b0011, 4'b1011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_branch(input logic [7:0] ir);
    return (ir[3:0] == 4'b0101) || (ir[3:0] == 4'b1001) || (ir[3:0] == 4'b1101);
  endfunction

  function automatic logic depends(input logic [7:0] younger, input logic [7:0] older);
    return ((rmask(younger) & wmask(older)) != 4'b0) ||
           (is_branch(younger) && sets_flags(older));
  endfunction

  logic       m_v1 = 1'b0;
  logic [7:0] m_ir1 = '0;
  logic       m_v2 = 1'b0;
  logic [7:0] m_ir2 = '0;
  logic       m_drain = 1'b0;
  logic       m_halt = 1'b0;
  int         m_cnt = 0;

  // One clock cycle: drive inputs, compare outputs, advance model at the edge.
  task automatic step(input logic ld, input logic [7:0] nir1,
                      input logic [7:0] i3, input logic v3,
                      input logic [7:0] i4, input logic v4, input logic bt);
    logic hz, e_load, e_stall, run, acc_stop;
    logic [1:0] e_rega;
    @(negedge clock);
    IR1Load     = ld;
    IR3wire_out = i3;
    IR3Valid    = v3;
    IR4wire_out = i4;
    IR4Valid    = v4;
    BranchTaken = bt;
    #1;
    run      = !m_drain && !m_halt;
    hz       = m_v1 && ((m_v2 && depends(m_ir1, m_ir2)) ||
                        (v3 && depends(m_ir1, i3)) ||
                        (v4 && depends(m_ir1, i4)));
    e_load   = run && m_v1 && !hz && !bt && (m_ir1[3:0] != 4'b0001);
    acc_stop = run && m_v1 && !hz && !bt && (m_ir1[3:0] == 4'b0001);
    e_stall  = m_halt || (m_v1 && (hz || !run) && !bt);
    e_rega   = (m_ir1[2:0] == 3'b111) ? 2'b01 : m_ir1[7:6];
    check_value("IR2Load",    {7'd0, IR2Load},    {7'd0, e_load});
    check_value("FetchStall", {7'd0, FetchStall}, {7'd0, e_stall});
    check_value("IR2Valid",   {7'd0, IR2Valid},   {7'd0, m_v2});
    check_value("Halted",     {7'd0, Halted},     {7'd0, m_halt});
    check_value("RegA",       {6'd0, RegA},       {6'd0, e_rega});
    check_value("RegB",       {6'd0, RegB},       {6'd0, m_ir1[5:4]});
`ifdef DECODE_PERF_CNT_EN
    check_value("StallCount", {{(8-CW){1'b0}}, StallCount}, 8'(m_cnt));
`endif
    @(posedge clock);
    if (run && e_stall && m_cnt < CNT_MAX) m_cnt++;
    if (m_drain) begin
      if (bt) m_drain = 1'b0;
      else if (!m_v2 && !v3 && !v4) begin
        m_drain = 1'b0;
        m_halt  = 1'b1;
      end
    end else if (acc_stop) begin
      m_drain = 1'b1;
    end
    m_v2 = e_load;
    if (e_load) m_ir2 = m_ir1;
    if (bt)                       m_v1 = 1'b0;
    else if (ld)                  m_v1 = 1'b1;
    else if (e_load || acc_stop)  m_v1 = 1'b0;
    #1;
    // Fetch presents the newly loaded IR1 just after the loading edge.
    if (ld) begin
      m_ir1       = nir1;
      IR1wire_out = nir1;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset       = 1'b1;
    IR1Load     = 1'b0;
    IR3Valid    = 1'b0;
    IR4Valid    = 1'b0;
    BranchTaken = 1'b0;
    #1;
    check_value("rst_IR2Valid",   {7'd0, IR2Valid},   8'd0);
    check_value("rst_Halted",     {7'd0, Halted},     8'd0);
    check_value("rst_FetchStall", {7'd0, FetchStall}, 8'd0);
    check_value("rst_IR2Load",    {7'd0, IR2Load},    8'd0);
    m_v1    = 1'b0;
    m_v2    = 1'b0;
    m_drain = 1'b0;
    m_halt  = 1'b0;
    m_cnt   = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset while draining
    step(1'b1, STOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, STOP, ADD_R1_R0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, NOP,  ADD_R1_R0, 1'b1, 8'h00, 1'b0, 1'b0);
    do_reset();
    step(1'b0, NOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // Hazard-free add issues the cycle after it lands in IR1
    step(1'b1, ADD_R1_R0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, NOP,       8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    check_value("add_in_ir2", {7'd0, IR2Valid}, 8'd1);

    // Register RAW against IR3 then IR4
    step(1'b1, ADD_R2_R3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, NOP, LD_R2, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, NOP, LD_R2, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, NOP, 8'h00, 1'b0, LD_R2, 1'b1, 1'b0);
    step(1'b0, NOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // Flag RAW for a branch, then flush while stalled
    step(1'b1, BZ, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, NOP, ADD_R1_R0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, NOP, ADD_R1_R0, 1'b1, 8'h00, 1'b0, 1'b1);
    check_value("flush_ir2v", {7'd0, IR2Valid}, 8'd0);
    step(1'b0, NOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // STOP drains and halts
    step(1'b1, ADD_R1_R0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, STOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, NOP, ADD_R2_R3, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, NOP, ADD_R2_R3, 1'b1, ADD_R1_R0, 1'b1, 1'b0);
    step(1'b0, NOP, 8'h00, 1'b0, ADD_R2_R3, 1'b1, 1'b0);
    step(1'b0, NOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, NOP, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    check_value("halt_held", {7'd0, Halted}, 8'd1);

    // Stall counter saturation
    do_reset();
    step(1'b1, ADD_R2_R3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, NOP, LD_R2, 1'b1, 8'h00, 1'b0, 1'b0);
`ifdef DECODE_PERF_CNT_EN
    check_value("cnt_sat", {{(8-CW){1'b0}}, StallCount}, 8'd3);
`endif

    // Randomized traffic
    do_reset();
    for (int i = 1; i <= 800; i++) begin
      if (i % 60 == 0) do_reset();
      step($urandom_range(0, 9) < 6, 8'($urandom),
           8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom),
           $urandom_range(0, 9) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
